rename_rob_alloc: RTL and testbench
===================================

Name: rename_rob_alloc

Overview:
- Rename/allocate stage, directly upstream of the 64-entry ROB.
- Takes up to two decoded instructions per cycle and assigns each a ROB id. The ROB id doubles as the physical register tag (preg).
- Looks up each source operand in a register alias table (RAT): it yields the producing ROB id, plus a flag saying whether the value is still in flight (in-ROB) or in the ARF.
- Registers the results into a one-entry output buffer that feeds the ROB/dispatch. Tracks ROB occupancy from allocations and commits, and stalls decode when the ROB is nearly full.

Parameters:
- ROB_WIDTH, 6, log2 of ROB depth; ROB ids are ROB_WIDTH bits and wrap modulo 2^ROB_WIDTH.
- AREG_WIDTH, 5, architectural register index width (32 GPRs; r0 is never renamed).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  pipeline flush; same effect as reset on all state
- dec_valid_i  in  2  per-slot valid from decode; packed (2'b10 illegal)
- dec_rd_i  in  2x AREG_WIDTH  destination areg per slot
- dec_w_reg_i  in  2  slot writes a GPR
- dec_rj_i, dec_rk_i  in  2x AREG_WIDTH each  source aregs per slot
- dec_ready_o  out  1  pair accepted this cycle when dec_valid_i[0] & dec_ready_o
- disp_valid_o  out  2  output buffer valid per slot
- disp_preg_o  out  2x ROB_WIDTH  allocated ROB id per slot
- disp_src_preg_o  out  2x2x ROB_WIDTH  [slot][0=rj,1=rk] producer ROB id
- disp_src_inrob_o  out  2x2  producer is in flight; 0 means read the ARF
- disp_ready_i  in  1  downstream consumed the buffer this cycle
- commit_valid_i  in  2  packed commit mask from the commit stage
- commit_areg_i  in  2x AREG_WIDTH  committed areg
- commit_preg_i  in  2x ROB_WIDTH  committed ROB id
- commit_w_reg_i  in  2  committed instruction wrote a GPR

Behaviour:
- Reset / flush (sync, rst_n low or flush_i high at the clock edge):
  - head=0, cnt=0, all RAT valid bits=0.
  - disp_valid_o=0, all other outputs 0.
  - Flush takes priority over every same-cycle event.
- State:
  - head (ROB_WIDTH bits), the next ROB id to allocate.
  - cnt (ROB_WIDTH+1 bits), occupied entries.
  - RAT: 32 entries of {valid, preg}.
  - Output buffer: 2 slots.
- Ready:
  - dec_ready_o = (!disp_valid_o[0] | disp_ready_i) & (cnt <= 2^ROB_WIDTH - 2).
  - Two free entries are always required, even for a single instruction.
  - Combinational from registered state and disp_ready_i; no dependence on dec_valid_i.
- Accept (acc = dec_valid_i[0] & dec_ready_o), with n = popcount of dec_valid_i:
  - slot0 preg = head; slot1 preg = head+1, wrapping.
  - head <= head+n.
  - Outputs appear the next cycle (1-cycle latency).
- Source lookup:
  - Index the RAT with rj/rk. inrob = RAT.valid, preg = RAT.preg.
  - areg 0 always gives inrob=0, preg=0.
  - Slot1 intra-pair bypass: if slot0 is valid with w_reg, rd!=0, and rd equals a slot1 source, that source gets inrob=1, preg = slot0 preg.
- RAT write on accept:
  - For each valid slot with w_reg and rd!=0: RAT[rd] <= {1, slot preg}.
  - Both slots writing the same rd: slot1 wins.
- Commit:
  - cnt decrements by popcount(commit_valid_i).
  - For each committing slot with w_reg: if RAT[areg].valid and RAT[areg].preg == commit_preg, clear valid.
  - A same-cycle rename write to that areg wins over the clear.
  - Same-cycle lookups see pre-update RAT contents. The ROB already holds the committing data, so no extra bypass is needed.
- cnt update: cnt <= cnt + n(acc) - popcount(commit_valid_i). Commit never exceeds cnt (caller guarantee; checked by assertion).
- Output buffer:
  - Loads on acc.
  - Holds while disp_valid_o[0] & !disp_ready_i.
  - Clears when disp_ready_i & !acc.
  - No bubbles: if disp_ready_i and acc occur in the same cycle, the buffer reloads.
- Wrap-around: head 63 allocates 63 and 0. The 0-flag/pointer wrap is implicit since cnt carries fullness.

Decomposition:
- Shared package gets:
  - the rename_out_pkg_t typedef (preg, src_preg[2], src_inrob[2], valid);
  - the ROB_WIDTH/AREG_WIDTH macros, reused from the existing defines header.
- Sub-module rename_rat:
  - 32-entry RAT with 4 read ports, 2 rename write ports, 2 commit-clear ports.
  - Priority: flush > rename write > commit clear.
- Top-level rename_rob_alloc keeps pointers, the counter, the bypass and the output buffer.

Test Plan:
- Reset, then pair {rd=r4 w_reg, rd=r5 w_reg} -> next cycle disp_preg=0,1; head=2; cnt=2; all src inrob=0.
- Dependent pair: slot0 rd=r7 (gets preg 2), slot1 rj=r7 -> slot1 src_preg[0]=2 with inrob=1. Later instruction reading r7 -> preg 2, inrob=1. Commit {r7, preg 2} -> following reader sees inrob=0.
- Fill: accept pairs until cnt=63 -> dec_ready_o=0 even for a single instruction. Commit one -> cnt=62 -> ready=1. Head wraps: ids 62,63 then 0,1.
- Backpressure: disp_ready_i=0 for 3 cycles with a pending decode pair -> outputs stable, dec_ready_o=0, head unchanged; on release the buffer reloads the same cycle.
- Same-cycle commit clear vs rename of the same areg r9 (commit preg 5, new preg 12) -> RAT[r9] = {1, 12}.
- flush_i with cnt=20 and buffer valid -> next cycle disp_valid_o=0, cnt=0, head=0, all lookups inrob=0; flush wins over a concurrent accept.

Source files
------------

// File: rtl/rename_rob_alloc_pkg.sv
// Shared types and widths for the rename / ROB-allocate slice.
package rename_rob_alloc_pkg;

    localparam int RRA_ROB_WIDTH  = 6;
    localparam int RRA_AREG_WIDTH = 5;

    // One dispatch slot as held in the output buffer.
    typedef struct packed {
        logic                          valid;
        logic [RRA_ROB_WIDTH-1:0]      preg;
        logic [1:0][RRA_ROB_WIDTH-1:0] src_preg;
        logic [1:0]                    src_inrob;
    } rename_out_pkg_t;

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/rename_rat.sv
// Register alias table: 4 combinational read ports, 2 rename writes, 2 commit clears.
// Write priority is reset/flush, then rename write (slot1 over slot0), then commit clear.
module rename_rat
    import rename_rob_alloc_pkg::*;
#(
    parameter int ROB_WIDTH  = RRA_ROB_WIDTH,
    parameter int AREG_WIDTH = RRA_AREG_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic [3:0][AREG_WIDTH-1:0]      i_rd_areg,
    output logic [3:0]                      o_rd_valid,
    output logic [3:0][ROB_WIDTH-1:0]       o_rd_preg,
    input  logic [1:0]                      i_wr_en,
    input  logic [1:0][AREG_WIDTH-1:0]      i_wr_areg,
    input  logic [1:0][ROB_WIDTH-1:0]       i_wr_preg,
    input  logic [1:0]                      i_clr_en,
    input  logic [1:0][AREG_WIDTH-1:0]      i_clr_areg,
    input  logic [1:0][ROB_WIDTH-1:0]       i_clr_preg
);

    localparam int NREG = 1 << AREG_WIDTH;

    logic [NREG-1:0]                r_valid;
    logic [NREG-1:0][ROB_WIDTH-1:0] r_preg;

    // r0 is hard-wired to "read the ARF".
    always_comb begin
        o_rd_valid = '0;
        o_rd_preg  = '0;
        for (int p = 0; p < 4; p++) begin
            if (i_rd_areg[p] != '0) begin
                o_rd_valid[p] = r_valid[i_rd_areg[p]];
                o_rd_preg[p]  = r_preg[i_rd_areg[p]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_valid <= '0;
            r_preg  <= '0;
        end else begin
            // Clear only if the committing id is still the youngest mapping.
            for (int c = 0; c < 2; c++) begin
                if (i_clr_en[c] && r_valid[i_clr_areg[c]] &&
                    (r_preg[i_clr_areg[c]] == i_clr_preg[c])) begin
                    r_valid[i_clr_areg[c]] <= 1'b0;
                end
            end
            for (int w = 0; w < 2; w++) begin
                if (i_wr_en[w]) begin
                    r_valid[i_wr_areg[w]] <= 1'b1;
                    r_preg[i_wr_areg[w]]  <= i_wr_preg[w];
                end
            end
        end
    end

endmodule

// File: rtl/rename_rob_alloc.sv
// Rename/allocate: assigns ROB ids to up to two instructions, looks up sources, 1-cycle latency.
// Stalls decode when the output buffer is held or fewer than two ROB entries are free.
module rename_rob_alloc
    import rename_rob_alloc_pkg::*;
#(
    parameter int ROB_WIDTH  = RRA_ROB_WIDTH,
    parameter int AREG_WIDTH = RRA_AREG_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic [1:0]                      dec_valid_i,
    input  logic [1:0][AREG_WIDTH-1:0]      dec_rd_i,
    input  logic [1:0]                      dec_w_reg_i,
    input  logic [1:0][AREG_WIDTH-1:0]      dec_rj_i,
    input  logic [1:0][AREG_WIDTH-1:0]      dec_rk_i,
    output logic                            dec_ready_o,
    output logic [1:0]                      disp_valid_o,
    output logic [1:0][ROB_WIDTH-1:0]       disp_preg_o,
    output logic [1:0][1:0][ROB_WIDTH-1:0]  disp_src_preg_o,
    output logic [1:0][1:0]                 disp_src_inrob_o,
    input  logic                            disp_ready_i,
    input  logic [1:0]                      commit_valid_i,
    input  logic [1:0][AREG_WIDTH-1:0]      commit_areg_i,
    input  logic [1:0][ROB_WIDTH-1:0]       commit_preg_i,
    input  logic [1:0]                      commit_w_reg_i
);

    localparam logic [ROB_WIDTH:0] CNT_LIMIT = (ROB_WIDTH+1)'((1 << ROB_WIDTH) - 2);

    logic [ROB_WIDTH-1:0]        r_head;
    logic [ROB_WIDTH:0]          r_cnt;
    rename_out_pkg_t [1:0]       r_buf;

    rename_out_pkg_t [1:0]       w_buf_nxt;
    logic                        w_acc;
    logic [1:0]                  w_alloc_n;
    logic [1:0]                  w_cmt_n;
    logic [1:0][ROB_WIDTH-1:0]   w_slot_preg;
    logic [3:0][AREG_WIDTH-1:0]  w_rat_rd_areg;
    logic [3:0]                  w_rat_rd_valid;
    logic [3:0][ROB_WIDTH-1:0]   w_rat_rd_preg;
    logic [1:0]                  w_rat_wr_en;
    logic [1:0]                  w_rat_clr_en;
    logic                        w_s0_def;

    assign dec_ready_o = (!r_buf[0].valid || disp_ready_i) && (r_cnt <= CNT_LIMIT);
    assign w_acc       = dec_valid_i[0] & dec_ready_o;
    assign w_alloc_n   = w_acc ? popcnt2(dec_valid_i) : 2'd0;
    assign w_cmt_n     = popcnt2(commit_valid_i);

    assign w_slot_preg[0] = r_head;
    assign w_slot_preg[1] = r_head + ROB_WIDTH'(1);

    // Read port order: slot0 rj, slot0 rk, slot1 rj, slot1 rk.
    assign w_rat_rd_areg = {dec_rk_i[1], dec_rj_i[1], dec_rk_i[0], dec_rj_i[0]};
    assign w_s0_def      = dec_valid_i[0] & dec_w_reg_i[0] & (dec_rd_i[0] != '0);
    assign w_rat_clr_en  = commit_valid_i & commit_w_reg_i;

    always_comb begin
        w_rat_wr_en = '0;
        for (int s = 0; s < 2; s++) begin
            w_rat_wr_en[s] = w_acc & dec_valid_i[s] & dec_w_reg_i[s] & (dec_rd_i[s] != '0);
        end
    end

    rename_rat #(
        .ROB_WIDTH  (ROB_WIDTH),
        .AREG_WIDTH (AREG_WIDTH)
    ) u_rat (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .i_rd_areg  (w_rat_rd_areg),
        .o_rd_valid (w_rat_rd_valid),
        .o_rd_preg  (w_rat_rd_preg),
        .i_wr_en    (w_rat_wr_en),
        .i_wr_areg  (dec_rd_i),
        .i_wr_preg  (w_slot_preg),
        .i_clr_en   (w_rat_clr_en),
        .i_clr_areg (commit_areg_i),
        .i_clr_preg (commit_preg_i)
    );

    always_comb begin
        w_buf_nxt = '0;
        for (int s = 0; s < 2; s++) begin
            if (dec_valid_i[s]) begin
                w_buf_nxt[s].valid = 1'b1;
                w_buf_nxt[s].preg  = w_slot_preg[s];
                for (int k = 0; k < 2; k++) begin
                    w_buf_nxt[s].src_preg[k]  = w_rat_rd_preg[s*2+k];
                    w_buf_nxt[s].src_inrob[k] = w_rat_rd_valid[s*2+k];
                end
            end
        end
        // Slot1 depends on slot0 of the same pair; the RAT has not seen it yet.
        if (w_s0_def && dec_valid_i[1]) begin
            for (int k = 0; k < 2; k++) begin
                if (w_rat_rd_areg[2+k] == dec_rd_i[0]) begin
                    w_buf_nxt[1].src_preg[k]  = w_slot_preg[0];
                    w_buf_nxt[1].src_inrob[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_head <= '0;
            r_cnt  <= '0;
            r_buf  <= '0;
        end else begin
            r_head <= r_head + ROB_WIDTH'(w_alloc_n);
            r_cnt  <= r_cnt + (ROB_WIDTH+1)'(w_alloc_n) - (ROB_WIDTH+1)'(w_cmt_n);
            if (w_acc) begin
                r_buf <= w_buf_nxt;
            end else if (disp_ready_i) begin
                r_buf <= '0;
            end
        end
    end

    always_comb begin
        disp_valid_o     = '0;
        disp_preg_o      = '0;
        disp_src_preg_o  = '0;
        disp_src_inrob_o = '0;
        for (int s = 0; s < 2; s++) begin
            disp_valid_o[s]     = r_buf[s].valid;
            disp_preg_o[s]      = r_buf[s].preg;
            disp_src_preg_o[s]  = r_buf[s].src_preg;
            disp_src_inrob_o[s] = r_buf[s].src_inrob;
        end
    end

    always @(posedge clk) begin
        if (rst_n && !flush_i) begin
            assert ((ROB_WIDTH+1)'(w_cmt_n) <= r_cnt);
            assert (dec_valid_i != 2'b10);
            assert (commit_valid_i != 2'b10);
        end
    end

endmodule

// File: tb/tb_rename_rob_alloc.sv
// Directed bench for rename_rob_alloc; expected dispatch records are queued at issue
// and popped by a monitor whenever the output buffer is consumed.
module tb_rename_rob_alloc;

    logic                 clk;
    logic                 rst_n;
    logic                 flush_i;
    logic [1:0]           dec_valid_i;
    logic [1:0][4:0]      dec_rd_i;
    logic [1:0]           dec_w_reg_i;
    logic [1:0][4:0]      dec_rj_i;
    logic [1:0][4:0]      dec_rk_i;
    logic                 dec_ready_o;
    logic [1:0]           disp_valid_o;
    logic [1:0][5:0]      disp_preg_o;
    logic [1:0][1:0][5:0] disp_src_preg_o;
    logic [1:0][1:0]      disp_src_inrob_o;
    logic                 disp_ready_i;
    logic [1:0]           commit_valid_i;
    logic [1:0][4:0]      commit_areg_i;
    logic [1:0][5:0]      commit_preg_i;
    logic [1:0]           commit_w_reg_i;

    typedef struct packed {
        logic [1:0]           v;
        logic [1:0][5:0]      p;
        logic [1:0][1:0][5:0] sp;
        logic [1:0][1:0]      si;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_tx   = 0;

    rename_rob_alloc dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush_i),
        .dec_valid_i      (dec_valid_i),
        .dec_rd_i         (dec_rd_i),
        .dec_w_reg_i      (dec_w_reg_i),
        .dec_rj_i         (dec_rj_i),
        .dec_rk_i         (dec_rk_i),
        .dec_ready_o      (dec_ready_o),
        .disp_valid_o     (disp_valid_o),
        .disp_preg_o      (disp_preg_o),
        .disp_src_preg_o  (disp_src_preg_o),
        .disp_src_inrob_o (disp_src_inrob_o),
        .disp_ready_i     (disp_ready_i),
        .commit_valid_i   (commit_valid_i),
        .commit_areg_i    (commit_areg_i),
        .commit_preg_i    (commit_preg_i),
        .commit_w_reg_i   (commit_w_reg_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec_set(input int v, input int rd0, input int w0, input int rj0, input int rk0,
                           input int rd1, input int w1, input int rj1, input int rk1);
        dec_valid_i    = 2'(v);
        dec_rd_i[0]    = 5'(rd0);
        dec_w_reg_i[0] = 1'(w0);
        dec_rj_i[0]    = 5'(rj0);
        dec_rk_i[0]    = 5'(rk0);
        dec_rd_i[1]    = 5'(rd1);
        dec_w_reg_i[1] = 1'(w1);
        dec_rj_i[1]    = 5'(rj1);
        dec_rk_i[1]    = 5'(rk1);
    endtask

    task automatic cmt_set(input int v, input int a0, input int p0, input int w0,
                           input int a1, input int p1, input int w1);
        commit_valid_i    = 2'(v);
        commit_areg_i[0]  = 5'(a0);
        commit_preg_i[0]  = 6'(p0);
        commit_w_reg_i[0] = 1'(w0);
        commit_areg_i[1]  = 5'(a1);
        commit_preg_i[1]  = 6'(p1);
        commit_w_reg_i[1] = 1'(w1);
    endtask

    task automatic sb_push(input int v, input int p0, input int p1,
                           input int sp00, input int si00, input int sp01, input int si01,
                           input int sp10, input int si10, input int sp11, input int si11);
        exp_t e;
        e.v        = 2'(v);
        e.p[0]     = 6'(p0);
        e.p[1]     = 6'(p1);
        e.sp[0][0] = 6'(sp00);
        e.si[0][0] = 1'(si00);
        e.sp[0][1] = 6'(sp01);
        e.si[0][1] = 1'(si01);
        e.sp[1][0] = 6'(sp10);
        e.si[1][0] = 1'(si10);
        e.sp[1][1] = 6'(sp11);
        e.si[1][1] = 1'(si11);
        sb.push_back(e);
    endtask

    // Present the already-driven decode pair for one edge; it must be accepted.
    task automatic go(input string nm);
        #1;
        check({nm, "_ready"}, 32'(dec_ready_o), 32'd1);
        @(posedge clk);
        #1;
        dec_valid_i = 2'b00;
    endtask

    always @(negedge clk) begin
        if (rst_n && disp_valid_o[0] && disp_ready_i) begin
            check($sformatf("tx%0d_sb_has_entry", n_tx), 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check($sformatf("tx%0d_valid", n_tx), 32'(disp_valid_o), 32'(mon_e.v));
                for (int s = 0; s < 2; s++) begin
                    if (mon_e.v[s]) begin
                        check($sformatf("tx%0d_s%0d_preg", n_tx, s),
                              32'(disp_preg_o[s]), 32'(mon_e.p[s]));
                        for (int k = 0; k < 2; k++) begin
                            check($sformatf("tx%0d_s%0d_src%0d_preg", n_tx, s, k),
                                  32'(disp_src_preg_o[s][k]), 32'(mon_e.sp[s][k]));
                            check($sformatf("tx%0d_s%0d_src%0d_inrob", n_tx, s, k),
                                  32'(disp_src_inrob_o[s][k]), 32'(mon_e.si[s][k]));
                        end
                    end
                end
            end
            n_tx++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $finish;
    end

    initial begin
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        disp_ready_i = 1'b1;
        dec_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cmt_set(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("rst_disp_valid", 32'(disp_valid_o), 32'd0);
        check("rst_disp_preg", 32'(disp_preg_o), 32'd0);
        check("rst_src_inrob", 32'(disp_src_inrob_o), 32'd0);
        check("rst_dec_ready", 32'(dec_ready_o), 32'd1);
        rst_n = 1'b1;

        // Independent pair from reset: ids 0,1, nothing in flight.
        dec_set(3, 4, 1, 1, 2, 5, 1, 3, 6);
        sb_push(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        go("t1");
        // Slot1 reads r7 written by slot0 of the same pair.
        dec_set(3, 7, 1, 4, 5, 8, 1, 7, 0);
        sb_push(3, 2, 3, 0, 1, 1, 1, 2, 1, 0, 0);
        go("t2");
        dec_set(1, 0, 0, 7, 8, 0, 0, 0, 0);
        sb_push(1, 4, 0, 2, 1, 3, 1, 0, 0, 0, 0);
        go("t3");
        // r7/p2 matches and clears; r5/p7 is stale and must not clear.
        cmt_set(3, 7, 2, 1, 5, 7, 1);
        tick();
        cmt_set(0, 0, 0, 0, 0, 0, 0);
        dec_set(3, 9, 1, 7, 5, 10, 1, 9, 4);
        sb_push(3, 5, 6, 2, 0, 1, 1, 5, 1, 0, 1);
        go("t5");
        // Both slots rename r11: slot1 mapping must survive.
        dec_set(3, 11, 1, 10, 0, 11, 1, 11, 9);
        sb_push(3, 7, 8, 6, 1, 0, 0, 7, 1, 5, 1);
        go("t6");
        // Slot0 has no GPR write, so slot1 reading r12 gets no bypass.
        dec_set(3, 12, 0, 11, 12, 13, 1, 12, 11);
        sb_push(3, 9, 10, 8, 1, 0, 0, 0, 0, 8, 1);
        go("t7");
        dec_set(1, 14, 1, 13, 0, 0, 0, 0, 0);
        sb_push(1, 11, 0, 10, 1, 0, 0, 0, 0, 0, 0);
        go("t8");
        // Commit r9/p5 races a rename of r9 to p12.
        cmt_set(1, 9, 5, 1, 0, 0, 0);
        dec_set(1, 9, 1, 9, 0, 0, 0, 0, 0);
        sb_push(1, 12, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        go("t9");
        cmt_set(0, 0, 0, 0, 0, 0, 0);
        dec_set(3, 0, 0, 9, 10, 0, 0, 9, 0);
        sb_push(3, 13, 14, 12, 1, 6, 1, 12, 1, 0, 0);
        go("t10");

        // Fill: cnt 12 -> 13 -> 63, head wraps through 62,63 / 0,1.
        dec_set(1, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_push(1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go("fill_single");
        for (int k = 0; k < 25; k++) begin
            dec_set(3, 0, 0, 0, 0, 0, 0, 0, 0);
            sb_push(3, (16 + 2*k) % 64, (17 + 2*k) % 64, 0, 0, 0, 0, 0, 0, 0, 0);
            go($sformatf("fill%0d", k));
        end
        dec_set(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("full_block_single", 32'(dec_ready_o), 32'd0);
        tick();
        cmt_set(1, 0, 0, 0, 0, 0, 0);
        #1;
        check("full_block_commit_cycle", 32'(dec_ready_o), 32'd0);
        tick();
        cmt_set(0, 0, 0, 0, 0, 0, 0);
        sb_push(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go("after_commit");

        // Free four entries, then stall the output buffer.
        cmt_set(3, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        cmt_set(0, 0, 0, 0, 0, 0, 0);
        disp_ready_i = 1'b0;
        dec_set(3, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_push(3, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        go("bp_a");
        dec_set(3, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d_dec_ready", c), 32'(dec_ready_o), 32'd0);
            check($sformatf("bp%0d_valid", c), 32'(disp_valid_o), 32'd3);
            check($sformatf("bp%0d_preg0", c), 32'(disp_preg_o[0]), 32'd3);
            check($sformatf("bp%0d_preg1", c), 32'(disp_preg_o[1]), 32'd4);
            tick();
        end
        disp_ready_i = 1'b1;
        sb_push(3, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        go("bp_release");

        // Drain to cnt 19, then one allocation held in the buffer (cnt 20).
        cmt_set(3, 0, 0, 0, 0, 0, 0);
        repeat (22) tick();
        cmt_set(0, 0, 0, 0, 0, 0, 0);
        disp_ready_i = 1'b0;
        dec_set(1, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_push(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go("pre_flush");

        // Flush alongside an accept that would otherwise rename r20/r21.
        flush_i      = 1'b1;
        disp_ready_i = 1'b1;
        dec_set(3, 20, 1, 0, 0, 21, 1, 0, 0);
        #1;
        check("flush_acc_ready", 32'(dec_ready_o), 32'd1);
        tick();
        flush_i = 1'b0;
        dec_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("flush_disp_valid", 32'(disp_valid_o), 32'd0);
        check("flush_disp_preg", 32'(disp_preg_o), 32'd0);
        check("flush_src_inrob", 32'(disp_src_inrob_o), 32'd0);

        dec_set(3, 1, 1, 20, 9, 2, 1, 11, 4);
        sb_push(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        go("post_flush");
        // Counter restarted at 0: pairs to 62 stay ready, one more single makes 63.
        for (int k = 0; k < 30; k++) begin
            dec_set(3, 0, 0, 0, 0, 0, 0, 0, 0);
            sb_push(3, 2 + 2*k, 3 + 2*k, 0, 0, 0, 0, 0, 0, 0, 0);
            go($sformatf("refill%0d", k));
        end
        dec_set(1, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_push(1, 62, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go("refill_single");
        #1;
        check("post_flush_full", 32'(dec_ready_o), 32'd0);

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
